// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control bundle, bubble constant and forwarding encodings for the control pipeline.
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_write;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: picks the EX operand source for one source register; EX/MEM beats MEM/WB, x0 never forwards.
module forwarding_unit
    import pipe_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] mem_rd,
    input  logic          wb_reg_write,
    input  logic [AW-1:0] wb_rd,
    output logic [1:0]    fwd
);

    logic hit_mem;
    logic hit_wb;

    always_comb begin
        hit_mem = mem_reg_write & (mem_rd != '0) & (mem_rd == rs);
        hit_wb  = wb_reg_write & (wb_rd != '0) & (wb_rd == rs);
        fwd     = hit_mem ? FWD_EXMEM : hit_wb ? FWD_MEMWB : FWD_RF;
    end

endmodule

// File: rtl/control_pipeline.sv
// control_pipeline: carries decoded control bits through ID/EX, EX/MEM and MEM/WB,
// inserting load-use bubbles, applying branch flushes and generating forwarding selects.
module control_pipeline
    import pipe_pkg::*;
#(
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs2,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_mem_to_reg,
    output logic              mem_reg_write,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  bubble_count
);

    ctrl_t             id_ctrl;
    ctrl_t             ex_ctrl_d, ex_ctrl_q;
    logic [REG_AW-1:0] ex_rd_d, ex_rd_q;
    logic [REG_AW-1:0] ex_rs1_d, ex_rs1_q;
    logic [REG_AW-1:0] ex_rs2_d, ex_rs2_q;
    logic              mem_mem_read_d, mem_mem_read_q;
    logic              mem_mem_write_d, mem_mem_write_q;
    logic              mem_mem_to_reg_d, mem_mem_to_reg_q;
    logic              mem_reg_write_d, mem_reg_write_q;
    logic [REG_AW-1:0] mem_rd_d, mem_rd_q;
    logic              wb_mem_to_reg_d, wb_mem_to_reg_q;
    logic              wb_reg_write_d, wb_reg_write_q;
    logic [REG_AW-1:0] wb_rd_d, wb_rd_q;
    logic [CNT_W-1:0]  bubble_count_d, bubble_count_q;
    logic              load_use;
    logic              bubble;
    logic              load;

    always_comb begin
        id_ctrl = '{branch: id_branch, mem_read: id_mem_read, mem_to_reg: id_mem_to_reg,
                    mem_write: id_mem_write, alu_src: id_alu_src, reg_write: id_reg_write};
        load_use = id_valid & ex_ctrl_q.mem_read & (ex_rd_q != '0)
                 & ((ex_rd_q == id_rs1) | (id_uses_rs2 & (ex_rd_q == id_rs2)));
        stall      = load_use & ~ex_branch_taken;
        flush_ifid = ex_branch_taken;
        // Only stall and flush bubbles are counted; an empty decode slot is not a hazard.
        bubble = ex_branch_taken | stall;
        load   = ~bubble & id_valid;
        ex_ctrl_d = load ? id_ctrl : BUBBLE;
        ex_rd_d   = load ? id_rd : '0;
        ex_rs1_d  = load ? id_rs1 : '0;
        ex_rs2_d  = load ? id_rs2 : '0;
        mem_mem_read_d   = ex_ctrl_q.mem_read;
        mem_mem_write_d  = ex_ctrl_q.mem_write;
        mem_mem_to_reg_d = ex_ctrl_q.mem_to_reg;
        mem_reg_write_d  = ex_ctrl_q.reg_write;
        mem_rd_d         = ex_rd_q;
        wb_mem_to_reg_d  = mem_mem_to_reg_q;
        wb_reg_write_d   = mem_reg_write_q;
        wb_rd_d          = mem_rd_q;
        bubble_count_d = (bubble & ~&bubble_count_q) ? bubble_count_q + CNT_W'(1) : bubble_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q        <= BUBBLE;
            ex_rd_q          <= '0;
            ex_rs1_q         <= '0;
            ex_rs2_q         <= '0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_rd_q         <= '0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_rd_q          <= '0;
            bubble_count_q   <= '0;
        end else begin
            ex_ctrl_q        <= ex_ctrl_d;
            ex_rd_q          <= ex_rd_d;
            ex_rs1_q         <= ex_rs1_d;
            ex_rs2_q         <= ex_rs2_d;
            mem_mem_read_q   <= mem_mem_read_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_rd_q         <= mem_rd_d;
            wb_mem_to_reg_q  <= wb_mem_to_reg_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_rd_q          <= wb_rd_d;
            bubble_count_q   <= bubble_count_d;
        end
    end

    forwarding_unit #(.AW(REG_AW)) u_fwd_a (
        .rs(ex_rs1_q), .mem_reg_write(mem_reg_write_q), .mem_rd(mem_rd_q),
        .wb_reg_write(wb_reg_write_q), .wb_rd(wb_rd_q), .fwd(fwd_a)
    );

    forwarding_unit #(.AW(REG_AW)) u_fwd_b (
        .rs(ex_rs2_q), .mem_reg_write(mem_reg_write_q), .mem_rd(mem_rd_q),
        .wb_reg_write(wb_reg_write_q), .wb_rd(wb_rd_q), .fwd(fwd_b)
    );

    always_comb begin
        ex_branch      = ex_ctrl_q.branch;
        ex_mem_read    = ex_ctrl_q.mem_read;
        ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
        ex_mem_write   = ex_ctrl_q.mem_write;
        ex_alu_src     = ex_ctrl_q.alu_src;
        ex_reg_write   = ex_ctrl_q.reg_write;
        ex_rd          = ex_rd_q;
        mem_mem_read   = mem_mem_read_q;
        mem_mem_write  = mem_mem_write_q;
        mem_mem_to_reg = mem_mem_to_reg_q;
        mem_reg_write  = mem_reg_write_q;
        mem_rd         = mem_rd_q;
        wb_mem_to_reg  = wb_mem_to_reg_q;
        wb_reg_write   = wb_reg_write_q;
        wb_rd          = wb_rd_q;
        bubble_count   = bubble_count_q;
    end

endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed vectors with hand-computed expectations; counter narrowed to 4 bits for saturation.
module tb_control_pipeline;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_ADD  = 6'b000001;
    localparam logic [5:0] C_ADDI = 6'b000011;
    localparam logic [5:0] C_LD   = 6'b011011;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          id_valid = 1'b0;
    logic [5:0]    id_c = '0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_uses_rs2 = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          stall, flush_ifid;
    logic          ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd;
    logic          mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
    logic          wb_mem_to_reg, wb_reg_write;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] bubble_count;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    control_pipeline #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_branch(id_c[5]), .id_mem_read(id_c[4]), .id_mem_to_reg(id_c[3]),
        .id_mem_write(id_c[2]), .id_alu_src(id_c[1]), .id_reg_write(id_c[0]),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
        .ex_branch_taken(ex_branch_taken), .stall(stall), .flush_ifid(flush_ifid),
        .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .bubble_count(bubble_count)
    );

    wire [5:0] ex_c  = {ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write};
    wire [3:0] mem_c = {mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write};
    wire [1:0] wb_c  = {wb_mem_to_reg, wb_reg_write};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [5:0] c, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2, input logic [AW-1:0] rd, input logic u);
        id_valid = v; id_c = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_uses_rs2 = u;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ex", 32'(ex_c), 0);
        chk("rst_mem", 32'(mem_c), 0);
        chk("rst_wb", 32'(wb_c), 0);
        chk("rst_cnt", 32'(bubble_count), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 0);
        tick(); tick();
        rst_n = 1'b1;
        // Pipeline flow of an addi x1
        set_id(1, C_ADDI, 0, 0, 1, 0);
        tick();
        chk("flow_ex", 32'(ex_c), 32'(C_ADDI));
        chk("flow_ex_rd", 32'(ex_rd), 1);
        set_id(0, C_NONE, 0, 0, 0, 0);
        tick();
        chk("flow_ex_idle", 32'(ex_c), 0);
        chk("flow_mem", 32'({mem_reg_write, mem_rd}), 32'({1'b1, 5'd1}));
        tick();
        chk("flow_wb", 32'({wb_reg_write, wb_rd}), 32'({1'b1, 5'd1}));
        chk("flow_cnt", 32'(bubble_count), 0);
        // Load-use: ld x5 then add x7 = x5 + x6
        set_id(1, C_LD, 0, 0, 5, 0);
        tick();
        chk("ld_ex", 32'({ex_mem_read, ex_rd}), 32'({1'b1, 5'd5}));
        set_id(1, C_ADD, 5, 6, 7, 1);
        #1 chk("lu_stall", 32'(stall), 1);
        tick();
        chk("lu_bubble", 32'({ex_c, ex_rd}), 0);
        chk("lu_cnt", 32'(bubble_count), 1);
        chk("lu_stall_clear", 32'(stall), 0);
        tick();
        chk("lu_add_ex", 32'({ex_c, ex_rd}), 32'({C_ADD, 5'd7}));
        chk("lu_fwd_a", 32'(fwd_a), 32'(2'b01));
        chk("lu_fwd_b", 32'(fwd_b), 0);
        chk("lu_cnt_hold", 32'(bubble_count), 1);
        // Forward priority: x3, x3, use x3
        set_id(1, C_ADD, 0, 0, 3, 1); tick();
        set_id(1, C_ADD, 0, 0, 3, 1); tick();
        set_id(1, C_ADD, 3, 3, 4, 1); tick();
        chk("fp_fwd", 32'({fwd_a, fwd_b}), 32'(4'b1010));
        set_id(1, C_ADD, 0, 0, 3, 1); tick();
        set_id(1, C_ADD, 0, 0, 9, 1); tick();
        set_id(1, C_ADD, 3, 3, 4, 1); tick();
        chk("fp_fwd_wb", 32'({fwd_a, fwd_b}), 32'(4'b0101));
        // x0 is never a hazard or forwarding source
        set_id(1, C_LD, 0, 0, 0, 0); tick();
        set_id(1, C_ADD, 0, 0, 8, 1);
        #1 chk("x0_stall", 32'(stall), 0);
        tick();
        chk("x0_ex", 32'({ex_c, ex_rd}), 32'({C_ADD, 5'd8}));
        chk("x0_fwd_a", 32'(fwd_a), 0);
        // rs2 only counts when the instruction reads it; then flush beats load-use
        set_id(1, C_LD, 0, 0, 5, 0); tick();
        set_id(1, C_ADD, 1, 5, 7, 0);
        #1 chk("rs2_unused", 32'(stall), 0);
        id_uses_rs2 = 1'b1;
        #1 chk("rs2_used", 32'(stall), 1);
        ex_branch_taken = 1'b1;
        #1 chk("br_stall", 32'(stall), 0);
        chk("br_flush", 32'(flush_ifid), 1);
        tick();
        ex_branch_taken = 1'b0;
        chk("br_bubble", 32'({ex_c, ex_rd}), 0);
        chk("br_cnt", 32'(bubble_count), 2);
        chk("br_flush_off", 32'(flush_ifid), 0);
        // 20 load-use stalls saturate a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            set_id(1, C_LD, 0, 0, 5, 0); tick();
            set_id(1, C_ADD, 5, 0, 6, 0); tick();
        end
        chk("sat_cnt", 32'(bubble_count), 15);
        set_id(1, C_ADD, 0, 0, 2, 0); tick();
        set_id(1, C_ADD, 0, 0, 3, 0); tick();
        chk("pre_rst_mem", 32'(mem_reg_write), 1);
        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ex", 32'({ex_c, ex_rd}), 0);
        chk("arst_mem", 32'({mem_c, mem_rd}), 0);
        chk("arst_wb", 32'({wb_c, wb_rd}), 0);
        chk("arst_cnt", 32'(bubble_count), 0);
        chk("arst_fwd", 32'({fwd_a, fwd_b, stall}), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
